// File: rtl/mul_seq_param.sv
// Sequential shift-and-add multiplier: operands A then B on a shared bus, one multiplier bit per clock.
// Define MUL_SEQ_SIGNED_EN for two's-complement operands (sign-extended A, subtract on the final bit).
module mul_seq_param #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 start,
  output logic [2*WIDTH-1:0]   data_out,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOADB,
    S_CALC,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   a_ext;
  logic [2*WIDTH-1:0]   term;
  logic                 last;

  always_comb begin
`ifdef MUL_SEQ_SIGNED_EN
    a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
`else
    a_ext = {{WIDTH{1'b0}}, a_q};
`endif
    term    = a_ext << cnt_q;
    last    = (cnt_q == CW'(WIDTH - 1));
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = data_in;
          state_d = S_LOADB;
        end
      end
      S_LOADB: begin
        b_d     = data_in;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        if (b_q[cnt_q]) begin
`ifdef MUL_SEQ_SIGNED_EN
          // The multiplier MSB carries weight -2^(WIDTH-1) in two's complement
          if (last) acc_d = acc_q - term;
          else      acc_d = acc_q + term;
`else
          acc_d = acc_q + term;
`endif
        end
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          prod_d  = acc_d;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_out = prod_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule
